wb_stage_pipe: RTL
==================

Name: wb_stage_pipe

Overview:
Parametrised write-back stage with its own MEM/WB pipeline register.
- Captures MEM-stage results and formats sub-word loads (byte/half/word, signed/unsigned).
- Selects among four write-back sources and drives the register-file write port.
- Supports pipeline stall and flush, so hazard control can hold or kill the WB slot.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
REG_AW, 5, register-file address width.
LANE_AW, 2, byte-offset bits used for load extraction; must equal log2(DATA_W/8).

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold the MEM/WB register contents.
flush  input  1  load a bubble into the MEM/WB register.
valid_mem  input  1  MEM stage holds a real instruction.
reg_write_mem  input  1  instruction writes the register file.
wb_sel_mem  input  2  source select: 0 ALU, 1 memory load, 2 link address (PC+8), 3 immediate/LUI value.
load_type_mem  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 LD (64-bit only); 6–7 treated as LW.
rd_mem  input  REG_AW  destination register.
alu_result_mem  input  DATA_W  ALU result; low LANE_AW bits form the load byte offset.
mem_dout_mem  input  DATA_W  raw data-memory read word.
link_mem  input  DATA_W  link address (PC+8).
imm_mem  input  DATA_W  upper-immediate value.
valid_wb  output  1  WB slot holds a valid instruction.
reg_write_wb  output  1  register-file write enable.
rd_wb  output  REG_AW  register-file write address.
reg_write_data_wb  output  DATA_W  register-file write data.

Behaviour:
- Reset: on rst=1 at a clock edge, clear all MEM/WB register fields to 0.
  - Outputs after reset: valid_wb=0, reg_write_wb=0, rd_wb=0, reg_write_data_wb=0.
- Register update priority at each edge: rst > flush > stall > normal load.
  - flush (even with stall=1): clear the valid and reg_write fields; other fields don't-care, implemented as 0.
  - stall=1, flush=0: hold all fields.
  - Otherwise: capture every *_mem input.
- Latency:
  - MEM→WB register is exactly 1 cycle.
  - Load formatting and source select are combinational from registered fields.
  - reg_write_data_wb is valid in the same cycle as valid_wb.
- Write enable: reg_write_wb = valid_r & reg_write_r & (rd_r != 0). Writes to r0 are always suppressed.
- Load extraction, using off = alu_result_r[LANE_AW-1:0]:
  - LB/LBU: byte at bits [8*off+7 : 8*off].
  - LH/LHU: halfword at lane off[LANE_AW-1:1]*16.
  - LW: word at lane off[LANE_AW-1:2]*32; sign-extended when DATA_W=64.
  - LD: full word; only legal when DATA_W=64. With DATA_W=32, LD is treated as LW.
  - Signed types sign-extend to DATA_W; unsigned types zero-extend.
- Misaligned addresses: with the optional feature off, the offending low offset bits are ignored (the access is forced to natural alignment).
- When wb_sel_r != 1, reg_write_data_wb is independent of mem_dout and load_type.
- reg_write_data_wb is driven by the mux even when valid_wb=0; consumers must gate on reg_write_wb.

Optional Feature:
Macro WB_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_wb (1 bit, reset 0).
  - misalign_wb = valid_r & (wb_sel_r==1) & offset not naturally aligned for load_type_r (half: off[0]; word: off[1:0]; double: off[2:0]).
  - When misalign_wb=1, reg_write_wb is forced to 0.
- When undefined: no port, no trap, loads always commit.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs nonzero → every output 0 on the cycle after reset.
- LB sign extension: wb_sel=1, LB, mem_dout=0x80FF_1234, alu_result=...3 → next cycle reg_write_data_wb=0xFFFF_FF80; LBU → 0x0000_0080.
- LH/LHU: mem_dout=0x8001_7FFE, offset 2 → LH gives 0xFFFF_8001, LHU gives 0x0000_8001; offset 0 → 0x0000_7FFE.
- Source mux: wb_sel=2, link=0x0040_0008 → data 0x0040_0008. wb_sel=3, imm=0x1234_0000 → data 0x1234_0000.
- r0 write suppression: rd=0, reg_write=1 → reg_write_wb=0.
- Stall/flush:
  - stall=1 for 3 cycles while the inputs change → outputs hold their old values.
  - flush=1 together with stall=1 → valid_wb=0, reg_write_wb=0 next cycle.
  - With WB_MISALIGN_TRAP_EN, LW at offset 1 → misalign_wb=1 and reg_write_wb=0.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB pipeline register, sub-word load formatting and write-back source select.
// Optional build macro WB_MISALIGN_TRAP_EN adds misalign_wb and suppresses misaligned load commits.
module wb_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int LANE_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_mem,
    input  logic              reg_write_mem,
    input  logic [1:0]        wb_sel_mem,
    input  logic [2:0]        load_type_mem,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic [DATA_W-1:0] alu_result_mem,
    input  logic [DATA_W-1:0] mem_dout_mem,
    input  logic [DATA_W-1:0] link_mem,
    input  logic [DATA_W-1:0] imm_mem,
`ifdef WB_MISALIGN_TRAP_EN
    output logic              misalign_wb,
`endif
    output logic              valid_wb,
    output logic              reg_write_wb,
    output logic [REG_AW-1:0] rd_wb,
    output logic [DATA_W-1:0] reg_write_data_wb
);

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [2:0] LT_LD  = 3'd5;

    logic              valid_d, valid_q;
    logic              reg_write_d, reg_write_q;
    logic [1:0]        wb_sel_d, wb_sel_q;
    logic [2:0]        load_type_d, load_type_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic [DATA_W-1:0] alu_d, alu_q;
    logic [DATA_W-1:0] dout_d, dout_q;
    logic [DATA_W-1:0] link_d, link_q;
    logic [DATA_W-1:0] imm_d, imm_q;

    // Misaligned offsets are masked down to natural alignment before lane selection.
    function automatic logic [DATA_W-1:0] fmt_load(input logic [2:0] lt,
                                                   input logic [LANE_AW-1:0] off,
                                                   input logic [DATA_W-1:0] raw);
        logic [LANE_AW-1:0] ho, wo;
        logic [DATA_W-1:0]  sb, sh, sw, res;
        ho = off & ~LANE_AW'(1);
        wo = off & ~LANE_AW'(3);
        sb = raw >> {off, 3'b000};
        sh = raw >> {ho, 3'b000};
        sw = raw >> {wo, 3'b000};
        case (lt)
            LT_LH:   res = DATA_W'($signed(sh[15:0]));
            LT_LHU:  res = DATA_W'(sh[15:0]);
            LT_LB:   res = DATA_W'($signed(sb[7:0]));
            LT_LBU:  res = DATA_W'(sb[7:0]);
            LT_LD:   res = (DATA_W == 64) ? raw : DATA_W'($signed(sw[31:0]));
            default: res = DATA_W'($signed(sw[31:0]));
        endcase
        return res;
    endfunction

`ifdef WB_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] lt,
                                           input logic [LANE_AW-1:0] off);
        logic [7:0] mask;
        case (lt)
            LT_LB, LT_LBU: mask = 8'h00;
            LT_LH, LT_LHU: mask = 8'h01;
            LT_LD:         mask = (DATA_W == 64) ? 8'h07 : 8'h03;
            default:       mask = 8'h03;
        endcase
        return (8'(off) & mask) != 8'h00;
    endfunction
`endif

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        wb_sel_d    = wb_sel_q;
        load_type_d = load_type_q;
        rd_d        = rd_q;
        alu_d       = alu_q;
        dout_d      = dout_q;
        link_d      = link_q;
        imm_d       = imm_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            wb_sel_d    = '0;
            load_type_d = '0;
            rd_d        = '0;
            alu_d       = '0;
            dout_d      = '0;
            link_d      = '0;
            imm_d       = '0;
        end else if (!stall) begin
            valid_d     = valid_mem;
            reg_write_d = reg_write_mem;
            wb_sel_d    = wb_sel_mem;
            load_type_d = load_type_mem;
            rd_d        = rd_mem;
            alu_d       = alu_result_mem;
            dout_d      = mem_dout_mem;
            link_d      = link_mem;
            imm_d       = imm_mem;
        end
    end

    // MEM/WB register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= '0;
            load_type_q <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            dout_q      <= '0;
            link_q      <= '0;
            imm_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            wb_sel_q    <= wb_sel_d;
            load_type_q <= load_type_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            dout_q      <= dout_d;
            link_q      <= link_d;
            imm_q       <= imm_d;
        end
    end

    logic trap;
`ifdef WB_MISALIGN_TRAP_EN
    assign trap        = valid_q & (wb_sel_q == 2'd1) & is_misaligned(load_type_q, alu_q[LANE_AW-1:0]);
    assign misalign_wb = trap;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        reg_write_data_wb = alu_q;
        case (wb_sel_q)
            2'd1:    reg_write_data_wb = fmt_load(load_type_q, alu_q[LANE_AW-1:0], dout_q);
            2'd2:    reg_write_data_wb = link_q;
            2'd3:    reg_write_data_wb = imm_q;
            default: reg_write_data_wb = alu_q;
        endcase
    end

    assign valid_wb     = valid_q;
    assign rd_wb        = rd_q;
    assign reg_write_wb = valid_q & reg_write_q & (rd_q != '0) & ~trap;

endmodule
